// File: rtl/stream_mux_rr_if.sv
// Valid/ready bundle between N_CH producer streams, the mux and its single consumer.
// The slave modport is the mux view; the master modport is the producer/consumer view.
interface stream_mux_rr_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]        in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_last;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic                   out_last;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel streaming mux with a registered output stage; the grant comes from sel
// or a round-robin arbiter and is held for a whole packet delimited by last.
//
// state     | meaning
// ST_IDLE   | no packet locked; grant from sel (mode=0) or round-robin search (mode=1)
// ST_LOCKED | a multi-beat packet is in flight; grant pinned to r_lock_ch until last
module stream_mux_rr #(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic             busy,
  stream_mux_rr_if.slave   bus
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [SEL_W:0]   N_CH_W  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] RR_INIT = SEL_W'(N_CH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_lock_ch;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic [SEL_W-1:0]  w_grant;
  logic              w_grant_vld;
  logic              w_can_load;
  logic              w_xfer;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [SEL_W-1:0]  r_out_ch;

  // Descending scan so the channel closest after r_rr_ptr is the one left standing.
  always_comb begin : grant_logic
    logic [SEL_W:0] v_idx;
    v_idx       = '0;
    w_grant     = '0;
    w_grant_vld = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_grant     = r_lock_ch;
      w_grant_vld = 1'b1;
    end else if (!mode) begin
      w_grant     = sel;
      w_grant_vld = ({1'b0, sel} < N_CH_W);
    end else begin
      for (int i = N_CH; i >= 1; i--) begin
        v_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
        if (v_idx >= N_CH_W) begin
          v_idx = v_idx - N_CH_W;
        end
        if (bus.in_valid[v_idx[SEL_W-1:0]]) begin
          w_grant     = v_idx[SEL_W-1:0];
          w_grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_grant == SEL_W'(k)) begin
        w_sel_valid = bus.in_valid[k];
        w_sel_last  = bus.in_last[k];
        w_sel_data  = bus.in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_can_load = !r_out_valid || bus.out_ready;
  assign w_xfer     = w_grant_vld && w_can_load && w_sel_valid;

  // Held low during reset so producers see no acceptance while the lock is being dropped.
  always_comb begin
    bus.in_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      bus.in_ready[k] = w_grant_vld && w_can_load && !rst && (w_grant == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_IDLE) begin
      if (w_xfer && !w_sel_last) begin
        w_state_nxt = ST_LOCKED;
      end
    end else begin
      if (w_xfer && w_sel_last) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // rr_ptr tracks the last completed packet in both modes so mode=1 resumes fairly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_ch <= '0;
      r_rr_ptr  <= RR_INIT;
    end else begin
      if ((r_state == ST_IDLE) && w_xfer && !w_sel_last) begin
        r_lock_ch <= w_grant;
      end
      if (w_xfer && w_sel_last) begin
        r_rr_ptr <= w_grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_can_load) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_sel_data;
        r_out_last <= w_sel_last;
        r_out_ch   <= w_grant;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_ch    = r_out_ch;
  assign busy          = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a packet-level reference model predicts grants
// and pushes expected beats; an independent monitor checks every accepted output beat.
module tb_stream_mux_rr;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [SW-1:0] sel;
  logic          busy;
  logic          mode3;
  logic [1:0]    sel3;
  logic          busy3;

  stream_mux_rr_if #(.N_CH(N), .DATA_W(DW)) bus ();
  stream_mux_rr_if #(.N_CH(3), .DATA_W(DW)) bus3 ();

  stream_mux_rr #(.N_CH(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .busy(busy), .bus(bus)
  );

  stream_mux_rr #(.N_CH(3), .DATA_W(DW)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .busy(busy3), .bus(bus3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic [DW-1:0] pd [N][256];
  logic          pl [N][256];
  int            hd [N];
  int            tl [N];

  beat_t sbq [$];
  int    ch_log [$];
  beat_t mb;

  int n_checks = 0;
  int n_fail   = 0;

  int valid_pct = 100;
  int ready_pct = 100;
  int stall_left = 0;
  bit rand_sel = 0;
  bit rand_mode = 0;

  bit m_locked = 0;
  bit m_ov = 0;
  int m_lock = 0;
  int m_rr = N - 1;
  int m_pkt = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_beat(int k, logic [DW-1:0] d, logic l);
    pd[k][tl[k]] = d;
    pl[k][tl[k]] = l;
    tl[k]++;
  endfunction

  function automatic void fill_random(int k, int nbeats, int maxlen);
    int len = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (len == 0) len = int'($urandom_range(maxlen, 1));
      len--;
      push_beat(k, DW'($urandom), (len == 0) || (i == nbeats - 1));
    end
  endfunction

  function automatic void clear_bufs();
    for (int k = 0; k < N; k++) begin
      hd[k] = 0;
      tl[k] = 0;
    end
  endfunction

  function automatic bit bufs_empty();
    bit e = 1;
    for (int k = 0; k < N; k++) if (hd[k] < tl[k]) e = 0;
    return e;
  endfunction

  function automatic void reset_model();
    m_locked = 0;
    m_ov = 0;
    m_lock = 0;
    m_rr = N - 1;
    m_pkt = 0;
    sbq.delete();
  endfunction

  // One clock: drive inputs after the edge, then predict grant/acceptance at the falling edge.
  task automatic step();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    int g;
    int c;
    bit gv;
    bit cl;
    bit xfer;
    beat_t b;
    @(posedge clk);
    #1;
    if (rand_mode) mode = 1'($urandom_range(1));
    if (rand_sel) sel = SW'($urandom_range(N - 1));
    for (int k = 0; k < N; k++) begin
      v[k] = (hd[k] < tl[k]) && ($urandom_range(99) < valid_pct);
      bus.in_valid[k] = v[k];
      bus.in_data[k*DW +: DW] = v[k] ? pd[k][hd[k]] : DW'($urandom);
      bus.in_last[k] = v[k] ? pl[k][hd[k]] : 1'($urandom);
    end
    if (stall_left > 0) begin
      bus.out_ready = 1'b0;
      stall_left--;
    end else begin
      bus.out_ready = ($urandom_range(99) < ready_pct);
    end
    @(negedge clk);
    cl = !m_ov || bus.out_ready;
    gv = 0;
    g = 0;
    if (m_locked) begin
      g = m_lock;
      gv = 1;
    end else if (!mode) begin
      g = int'(sel);
      gv = (g < N);
    end else begin
      for (int j = 1; j <= N; j++) begin
        c = (m_rr + j) % N;
        if (!gv && v[c]) begin
          g = c;
          gv = 1;
        end
      end
    end
    exp_rdy = '0;
    if (gv && cl) exp_rdy[g] = 1'b1;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(m_locked));
    check("out_valid", 64'(bus.out_valid), 64'(m_ov));
    xfer = gv && cl && v[g];
    if (xfer) begin
      b.ch = SW'(g);
      b.d = pd[g][hd[g]];
      b.l = pl[g][hd[g]];
      sbq.push_back(b);
      if (b.l) begin
        m_locked = 0;
        m_rr = g;
        m_pkt = 0;
      end else begin
        m_locked = 1;
        m_lock = g;
        m_pkt++;
      end
      hd[g]++;
    end
    if (cl) m_ov = xfer;
  endtask

  task automatic drain(string name, int maxc);
    int c = 0;
    while (!(bufs_empty() && sbq.size() == 0 && !m_ov) && c < maxc) begin
      step();
      c++;
    end
    check(name, 64'(c < maxc), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.in_last = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    clear_bufs();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got beat ch=%0d data=%0h, expected none", bus.out_ch, bus.out_data);
      end else begin
        mb = sbq.pop_front();
        check("out_ch", 64'(bus.out_ch), 64'(mb.ch));
        check("out_data", 64'(bus.out_data), 64'(mb.d));
        check("out_last", 64'(bus.out_last), 64'(mb.l));
      end
      ch_log.push_back(int'(bus.out_ch));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lock [6] = '{1, 1, 1, 2, 3, 0};
    mode = 1'b0;
    sel = '0;
    mode3 = 1'b0;
    sel3 = 2'd0;
    bus3.in_valid = '0;
    bus3.in_data = '0;
    bus3.in_last = '0;
    bus3.out_ready = 1'b0;
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.in_last = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_out_ch", 64'(bus.out_ch), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    reset_model();
    clear_bufs();

    // Fixed pass-through, sel=2: only ch2 may be accepted.
    mode = 1'b0;
    sel = 2'd2;
    push_beat(2, 8'hA5, 1'b1);
    push_beat(0, 8'h01, 1'b1);
    push_beat(1, 8'h02, 1'b1);
    push_beat(3, 8'h03, 1'b1);
    ch_log.delete();
    repeat (4) step();
    clear_bufs();
    drain("pass_drain", 10);
    check("pass_count", 64'(ch_log.size()), 64'(1));
    if (ch_log.size() > 0) check("pass_ch", 64'(ch_log[0]), 64'(2));

    // N_CH=3 instance: sel out of range grants nothing, in-range sel grants.
    mode3 = 1'b0;
    sel3 = 2'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus3.in_valid = 3'b111;
      bus3.in_data = {8'h33, 8'h22, 8'h11};
      bus3.in_last = 3'b111;
      bus3.out_ready = 1'b1;
      @(negedge clk);
      check("oor_in_ready", 64'(bus3.in_ready), 64'(0));
      check("oor_out_valid", 64'(bus3.out_valid), 64'(0));
    end
    sel3 = 2'd2;
    @(negedge clk);
    check("sel3_in_ready", 64'(bus3.in_ready), 64'(3'b100));
    @(negedge clk);
    check("sel3_out_valid", 64'(bus3.out_valid), 64'(1));
    check("sel3_out_ch", 64'(bus3.out_ch), 64'(2));
    check("sel3_out_data", 64'(bus3.out_data), 64'(8'h33));
    bus3.in_valid = '0;

    // Backpressure with random sel changes, including mid-packet.
    ch_log.delete();
    rand_sel = 1;
    valid_pct = 80;
    ready_pct = 60;
    stall_left = 4;
    for (int i = 0; i < 16; i++) push_beat(int'($urandom_range(N - 1)), DW'($urandom), 1'($urandom_range(1)));
    for (int k = 0; k < N; k++) if (tl[k] > 0) pl[k][tl[k]-1] = 1'b1;
    drain("bp_drain", 600);
    check("bp_count", 64'(ch_log.size()), 64'(16));
    rand_sel = 0;

    // Round-robin fairness with single-beat packets on all channels.
    do_reset();
    ch_log.delete();
    mode = 1'b1;
    valid_pct = 100;
    ready_pct = 100;
    for (int k = 0; k < N; k++) for (int i = 0; i < 8; i++) push_beat(k, DW'($urandom), 1'b1);
    drain("rr_drain", 100);
    check("rr_count", 64'(ch_log.size()), 64'(32));
    foreach (ch_log[i]) check("rr_order", 64'(ch_log[i]), 64'(i % N));

    // Packet lock: move the pointer to ch0, then ch1 sends a 3-beat packet against competitors.
    push_beat(0, 8'h77, 1'b1);
    drain("lock_pre", 20);
    ch_log.delete();
    push_beat(1, 8'h10, 1'b0);
    push_beat(1, 8'h11, 1'b0);
    push_beat(1, 8'h12, 1'b1);
    push_beat(0, 8'h20, 1'b1);
    push_beat(2, 8'h30, 1'b1);
    push_beat(3, 8'h40, 1'b1);
    drain("lock_drain", 40);
    check("lock_count", 64'(ch_log.size()), 64'(6));
    foreach (ch_log[i]) if (i < 6) check("lock_order", 64'(ch_log[i]), 64'(exp_lock[i]));

    // Random mix of modes, sel, packet lengths, valid gaps and backpressure.
    clear_bufs();
    ch_log.delete();
    rand_mode = 1;
    rand_sel = 1;
    valid_pct = 70;
    ready_pct = 70;
    for (int k = 0; k < N; k++) fill_random(k, 40, 4);
    drain("rand_drain", 3000);
    check("rand_count", 64'(ch_log.size()), 64'(160));
    rand_mode = 0;
    rand_sel = 0;

    // Reset after beat 2 of a 4-beat packet.
    clear_bufs();
    mode = 1'b1;
    valid_pct = 100;
    ready_pct = 100;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 4; i++) push_beat(k, DW'($urandom), i == 3);
    end
    begin
      int c = 0;
      while (!(m_locked && m_pkt == 2) && c < 20) begin
        step();
        c++;
      end
      check("mid_reach", 64'(c < 20), 64'(1));
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_in_ready", 64'(bus.in_ready), 64'(0));
    bus.in_valid = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    ch_log.delete();
    drain("post_rst_drain", 200);
    check("post_rst_first_ch", 64'((ch_log.size() > 0) ? ch_log[0] : -1), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
